per_gpio_bank: RTL and testbench
================================

Name: per_gpio_bank

Overview:
Parametrised GPIO/LED peripheral on the openMSP430 peripheral bus. Successor to the single-bit LED latch at peripheral word 0. Provides:
- WIDTH channels, each with its own direction.
- Atomic set/clear/toggle output writes.
- Synchronised inputs.
- Per-channel edge-detect interrupt flags.
Instantiated beside the core. Its per_dout is OR-ed into the core's per_dout.

Parameters:
BASE_ADDR, 8'h00, peripheral word base address; must be 16-word aligned (BASE_ADDR[3:0]==0)
WIDTH, 8, channel count, 1..16
SYNC_STAGES, 2, input synchroniser depth, 2..4

Ports:
clk  in  1  core clock (dco_clk domain)
rst  in  1  asynchronous active-high reset
per_addr  in  8  peripheral word address
per_din  in  16  write data from core
per_en  in  1  peripheral access strobe, high active
per_we  in  2  byte write enables: [0]=bits 7:0, [1]=bits 15:8
per_dout  out  16  read data; 0 when not selected
gpio_in  in  WIDTH  asynchronous pad inputs
gpio_out  out  WIDTH  output values
gpio_oe  out  WIDTH  output enables, 1=drive
irq  out  1  level interrupt request

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All registers clear to 0: OUT, DIR, IFG, IE, IES, sync chain, prime counter, blink state. gpio_out=0, gpio_oe=0, irq=0, per_dout=0.
- Select: sel = per_en & (per_addr[7:4]==BASE_ADDR[7:4]). Register offset = per_addr[3:0].
- Write: occurs on the clk edge where sel & per_we!=0. Each byte lane is written only if its per_we bit is set.
- Bits at positions ≥WIDTH read 0 and ignore writes. Unmapped offsets read 0 and ignore writes.
- Read: per_dout is combinational from current register state while sel & per_we==0, otherwise 0. Zero wait states.
- Register map (word offsets):
  - 0 OUT: rw.
  - 1 OUT_SET: w1s into OUT; reads OUT.
  - 2 OUT_CLR: w1c into OUT; reads OUT.
  - 3 OUT_TGL: write-1-toggles OUT; reads OUT.
  - 4 DIR: rw; 1=output.
  - 5 IN: ro; synchronised input.
  - 6 IFG: rw1c.
  - 7 IE: rw.
  - 8 IES: rw; 0=rising, 1=falling.
- Outputs: gpio_out=OUT & DIR; gpio_oe=DIR. Both update 1 cycle after the write edge, registered.
- Input path: gpio_in passes through SYNC_STAGES flops giving in_s. A further flop gives in_d.
  - IN reads in_s, so latency is SYNC_STAGES cycles.
- Priming: a 3-bit prime counter counts from 0 up to SYNC_STAGES+1 after reset, then holds. Edge detection is disabled until it saturates, so pads already high at reset release raise no flags.
- Edge detection, per channel: rise = in_s & ~in_d; fall = ~in_s & in_d; edge = IES ? fall : rise. An edge sets IFG regardless of IE or DIR.
- Simultaneous events on the same bit:
  - Hardware edge and software w1c in the same cycle: set wins.
  - OUT writes via offset 0 and via offsets 1-3 are mutually exclusive, because one address per access.
- irq = |(IFG & IE), registered, 1-cycle latency. irq stays high until software clears all enabled flags.
- Reset mid-access: asynchronous clear overrides everything. No partial write survives.

Optional Feature:
Macro GPIO_BLINK_EN adds hardware blink.
- Enabled:
  - Offset 9 BLINK (rw, WIDTH bits) selects the channels that blink.
  - Offset 10 BLINK_DIV (rw, 16 bits) sets the divider.
  - A 16-bit down-counter loads BLINK_DIV on any BLINK_DIV write. On reaching 0 it reloads and toggles OUT bits where BLINK=1, so the period is 2×(BLINK_DIV+1) cycles.
  - BLINK_DIV=0: counter stopped, no toggling.
  - A software OUT/OUT_SET/OUT_CLR/OUT_TGL write in the same cycle as a blink toggle takes priority for written bits.
- Disabled: offsets 9/10 read 0 and ignore writes. No counter logic is synthesised.

Test Plan:
1. Reset, WIDTH=8: write DIR=16'h00FF then OUT=16'h00A5 → gpio_oe=8'hFF, gpio_out=8'hA5 one cycle after the write edge; read offset 0 returns 16'h00A5.
2. OUT=8'hA5, write OUT_SET=16'h0003, OUT_CLR=16'h0080, OUT_TGL=16'h00FF → OUT progresses A7, 27, D8.
3. IES=0, IE=16'h0001; gpio_in[0] 0→1 → IN[0]=1 after 2 cycles; IFG[0]=1; irq=1 one cycle later. Write IFG=16'h0001 → irq=0. Repeat with IES=1 and a 1→0 edge → same result.
4. gpio_in=8'hFF held across reset release → IFG stays 0 for 100 cycles. Write per_we=2'b10, OUT=16'hFFFF → OUT unchanged (high lane only, bits ≥WIDTH ignored).
5. Rising edge on bit 2 in the same cycle as IFG w1c of bit 2 → IFG[2]=1 afterwards. Assert rst mid-write → all outputs 0 immediately.
6. GPIO_BLINK_EN defined: DIR=1, BLINK=1, BLINK_DIV=3 → gpio_out[0] toggles every 4 cycles, period 8. Undefined: reading offset 10 returns 0.

Source files
------------

// File: rtl/per_gpio_bank.sv
// GPIO/LED bank on the openMSP430 peripheral bus: per-channel direction, atomic
// set/clear/toggle, synchronised inputs, edge flags. Optional blink: GPIO_BLINK_EN.
module per_gpio_bank #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         WIDTH       = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       per_addr,
  input  logic [15:0]      per_din,
  input  logic             per_en,
  input  logic [1:0]       per_we,
  output logic [15:0]      per_dout,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic             sel, wr_en, rd_en, primed;
  logic [3:0]       offset;
  logic [15:0]      lane16, rd_word;
  logic [WIDTH-1:0] wmask, wdata;
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, ifg_q, ifg_d, ie_q, ie_d, ies_q, ies_d;
  logic [WIDTH-1:0] out_base, out_sw_mask, out_sw_val, ifg_clr;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_s, in_d_q, edge_det;
  logic [WIDTH-1:0] gpio_out_q, gpio_oe_q;
  logic [2:0]       prime_q;
  logic             irq_q;
  logic             unused_din;

  assign sel    = per_en & (per_addr[7:4] == BASE_ADDR[7:4]);
  assign offset = per_addr[3:0];
  assign wr_en  = sel & (|per_we);
  assign rd_en  = sel & ~(|per_we);
  assign lane16 = {{8{per_we[1]}}, {8{per_we[0]}}};
  assign wmask  = lane16[WIDTH-1:0];
  assign wdata  = per_din[WIDTH-1:0] & wmask;
  assign unused_din = ^{per_din, lane16};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_q[gi] <= '0;
          else     sync_q[gi] <= gpio_in;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_q[gi] <= '0;
          else     sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign in_s   = sync_q[SYNC_STAGES-1];
  // Edges are ignored until the synchroniser and in_d have filled after reset.
  assign primed = (prime_q == PRIME_MAX);
  assign edge_det = primed ? ((ies_q & ~in_s & in_d_q) | (~ies_q & in_s & ~in_d_q))
                           : '0;

`ifdef GPIO_BLINK_EN
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [15:0]      div_q, div_d, cnt_q, cnt_d;
  logic             div_wr, blink_tick;

  always_comb begin
    div_wr     = wr_en && (offset == 4'd10);
    blink_d    = (wr_en && offset == 4'd9) ? ((blink_q & ~wmask) | wdata) : blink_q;
    div_d      = div_wr ? ((div_q & ~lane16) | (per_din & lane16)) : div_q;
    blink_tick = !div_wr && (div_q != 16'd0) && (cnt_q == 16'd0);
    cnt_d      = cnt_q;
    if (div_wr)                 cnt_d = div_d;
    else if (div_q != 16'd0)    cnt_d = blink_tick ? div_q : cnt_q - 16'd1;
    out_base   = blink_tick ? (out_q ^ blink_q) : out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      blink_q <= blink_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign out_base = out_q;
`endif

  always_comb begin
    out_sw_mask = '0;
    out_sw_val  = '0;
    dir_d       = dir_q;
    ie_d        = ie_q;
    ies_d       = ies_q;
    ifg_clr     = '0;
    if (wr_en) begin
      case (offset)
        4'd0: begin out_sw_mask = wmask; out_sw_val = per_din[WIDTH-1:0]; end
        4'd1: begin out_sw_mask = wdata; out_sw_val = '1;     end
        4'd2: begin out_sw_mask = wdata; out_sw_val = '0;     end
        4'd3: begin out_sw_mask = wdata; out_sw_val = ~out_q; end
        4'd4: dir_d   = (dir_q & ~wmask) | wdata;
        4'd6: ifg_clr = wdata;
        4'd7: ie_d    = (ie_q  & ~wmask) | wdata;
        4'd8: ies_d   = (ies_q & ~wmask) | wdata;
        default: ;
      endcase
    end
    // Software-written bits override a coincident blink toggle.
    out_d = (out_base & ~out_sw_mask) | (out_sw_val & out_sw_mask);
    // A hardware edge beats a same-cycle software clear.
    ifg_d = (ifg_q & ~ifg_clr) | edge_det;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      dir_q      <= '0;
      ifg_q      <= '0;
      ie_q       <= '0;
      ies_q      <= '0;
      in_d_q     <= '0;
      prime_q    <= '0;
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      dir_q      <= dir_d;
      ifg_q      <= ifg_d;
      ie_q       <= ie_d;
      ies_q      <= ies_d;
      in_d_q     <= in_s;
      if (!primed) prime_q <= prime_q + 3'd1;
      gpio_out_q <= out_q & dir_q;
      gpio_oe_q  <= dir_q;
      irq_q      <= |(ifg_q & ie_q);
    end
  end

  always_comb begin
    rd_word = '0;
    case (offset)
      4'd0, 4'd1, 4'd2, 4'd3: rd_word = 16'(out_q);
      4'd4: rd_word = 16'(dir_q);
      4'd5: rd_word = 16'(in_s);
      4'd6: rd_word = 16'(ifg_q);
      4'd7: rd_word = 16'(ie_q);
      4'd8: rd_word = 16'(ies_q);
`ifdef GPIO_BLINK_EN
      4'd9:  rd_word = 16'(blink_q);
      4'd10: rd_word = div_q;
`endif
      default: rd_word = '0;
    endcase
  end

  assign per_dout = rd_en ? rd_word : 16'h0000;
  assign gpio_out = gpio_out_q;
  assign gpio_oe  = gpio_oe_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_per_gpio_bank.sv
// Self-checking bench for per_gpio_bank: sample-history reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_per_gpio_bank;
  localparam int         W    = 8;
  localparam int         SS   = 2;
  localparam logic [7:0] BASE = 8'h20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   per_addr = '0;
  logic [15:0]  per_din = '0;
  logic         per_en = 1'b0;
  logic [1:0]   per_we = '0;
  logic [15:0]  per_dout;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out, gpio_oe;
  logic         irq;

  int n_assert = 0;
  int n_fail   = 0;

  per_gpio_bank #(.BASE_ADDR(BASE), .WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
    .per_we(per_we), .per_dout(per_dout), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus the history of pad samples per edge.
  logic [W-1:0] m_out, m_dir, m_ifg, m_ie, m_ies, m_blink;
  logic [15:0]  m_div;
  int           m_bn, m_edges;
  logic [W-1:0] hist [0:7];
  logic [W-1:0] exp_gout, exp_oe;
  logic         exp_irq;
  logic [W-1:0] t_ins, t_ind, t_ev, t_msk, t_wd, t_tog, t_new, t_clr;
  logic [15:0]  t_lane;
  logic         t_wr;
  logic [3:0]   t_off;

  function automatic logic [15:0] m_read(input logic [3:0] off);
    case (off)
      4'd0, 4'd1, 4'd2, 4'd3: return 16'(m_out);
      4'd4: return 16'(m_dir);
      4'd5: return 16'(hist[SS-1]);
      4'd6: return 16'(m_ifg);
      4'd7: return 16'(m_ie);
      4'd8: return 16'(m_ies);
`ifdef GPIO_BLINK_EN
      4'd9:  return 16'(m_blink);
      4'd10: return m_div;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = '0; m_dir = '0; m_ifg = '0; m_ie = '0; m_ies = '0; m_blink = '0;
      m_div = '0; m_bn = 0; m_edges = 0;
      for (int i = 0; i < 8; i++) hist[i] = '0;
      exp_gout = '0; exp_oe = '0; exp_irq = 1'b0;
    end else begin
      exp_gout = m_out & m_dir;
      exp_oe   = m_dir;
      exp_irq  = |(m_ifg & m_ie);
      t_ins = hist[SS-1];
      t_ind = hist[SS];
      t_ev  = (m_edges >= SS + 1) ? (m_ies ? (~t_ins & t_ind) : (t_ins & ~t_ind)) : '0;
      t_wr  = per_en && (per_addr[7:4] == BASE[7:4]) && (per_we != 2'b00);
      t_off = per_addr[3:0];
      t_lane = {{8{per_we[1]}}, {8{per_we[0]}}};
      t_msk = t_lane[W-1:0];
      t_wd  = per_din[W-1:0] & t_msk;
      t_tog = '0;
      t_clr = '0;
`ifdef GPIO_BLINK_EN
      if (m_div != 16'd0 && !(t_wr && t_off == 4'd10)) begin
        m_bn++;
        if (m_bn % (int'(m_div) + 1) == 0) t_tog = m_blink;
      end
`endif
      t_new = m_out ^ t_tog;
      if (t_wr) begin
        case (t_off)
          4'd0: t_new = (t_new & ~t_msk) | (per_din[W-1:0] & t_msk);
          4'd1: t_new = t_new | t_wd;
          4'd2: t_new = t_new & ~t_wd;
          4'd3: t_new = (t_new & ~t_wd) | (~m_out & t_wd);
          4'd4: m_dir = (m_dir & ~t_msk) | t_wd;
          4'd6: t_clr = t_wd;
          4'd7: m_ie  = (m_ie & ~t_msk) | t_wd;
          4'd8: m_ies = (m_ies & ~t_msk) | t_wd;
`ifdef GPIO_BLINK_EN
          4'd9:  m_blink = (m_blink & ~t_msk) | t_wd;
          4'd10: begin m_div = (m_div & ~t_lane) | (per_din & t_lane); m_bn = 0; end
`endif
          default: ;
        endcase
      end
      m_ifg = (m_ifg & ~t_clr) | t_ev;
      m_out = t_new;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gpio_in;
      if (m_edges < 1000) m_edges++;
    end
  end

  always @(negedge clk) begin
    chk("gpio_out", 32'(gpio_out), 32'(exp_gout));
    chk("gpio_oe",  32'(gpio_oe),  32'(exp_oe));
    chk("irq",      32'(irq),      32'(exp_irq));
    if (per_en && per_addr[7:4] == BASE[7:4] && per_we == 2'b00)
      chk("per_dout", 32'(per_dout), 32'(m_read(per_addr[3:0])));
    else
      chk("per_dout_idle", 32'(per_dout), 32'h0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [15:0] d, input logic [1:0] we);
    per_en = 1'b1; per_addr = BASE | 8'(off); per_din = d; per_we = we;
    @(posedge clk); #1;
    per_en = 1'b0; per_we = 2'b00;
    $display("wr  off=%0d data=%h we=%b", off, d, we);
  endtask

  task automatic rd(input logic [3:0] off, input logic [15:0] exp);
    per_en = 1'b1; per_addr = BASE | 8'(off); per_we = 2'b00;
    #2;
    $display("rd  off=%0d data=%h exp=%h", off, per_dout, exp);
    chk($sformatf("read_off%0d", off), 32'(per_dout), 32'(exp));
    @(posedge clk); #1;
    per_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_gpio_out", 32'(gpio_out), 32'h0);
    chk("reset_oe", 32'(gpio_oe), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rd(4'd0, 16'h0000);

    // Direction and output value
    wr(4'd4, 16'h00FF, 2'b11);
    wr(4'd0, 16'h00A5, 2'b11);
    chk("gpio_out_latency", 32'(gpio_out), 32'h00);
    cyc(1);
    chk("gpio_oe_ff", 32'(gpio_oe), 32'hFF);
    chk("gpio_out_a5", 32'(gpio_out), 32'hA5);
    rd(4'd0, 16'h00A5);

    // Atomic set / clear / toggle
    wr(4'd1, 16'h0003, 2'b11); rd(4'd1, 16'h00A7);
    wr(4'd2, 16'h0080, 2'b11); rd(4'd2, 16'h0027);
    wr(4'd3, 16'h00FF, 2'b11); rd(4'd3, 16'h00D8);
    wr(4'd0, 16'hFFFF, 2'b10); rd(4'd0, 16'h00D8);
    wr(4'd8, 16'hFFFF, 2'b11); rd(4'd8, 16'h00FF);
    wr(4'd8, 16'h0000, 2'b11);
    per_en = 1'b1; per_addr = 8'h30; per_we = 2'b00; #2;
    chk("unselected_read", 32'(per_dout), 32'h0);
    cyc(1); per_en = 1'b0;

    // Rising edge on bit 0
    wr(4'd7, 16'h0001, 2'b11);
    gpio_in[0] = 1'b1;
    cyc(2);
    rd(4'd5, 16'h0001);
    rd(4'd6, 16'h0001);
    chk("irq_rise", 32'(irq), 32'h1);
    wr(4'd6, 16'h0001, 2'b11);
    cyc(1);
    chk("irq_cleared", 32'(irq), 32'h0);

    // Falling edge on bit 0
    wr(4'd8, 16'h0001, 2'b11);
    gpio_in[0] = 1'b0;
    cyc(2);
    rd(4'd5, 16'h0000);
    rd(4'd6, 16'h0001);
    chk("irq_fall", 32'(irq), 32'h1);
    wr(4'd6, 16'h0001, 2'b11);
    cyc(1);
    chk("irq_cleared2", 32'(irq), 32'h0);
    wr(4'd8, 16'h0000, 2'b11);

    // Edge on bit 2 coincident with its software clear
    gpio_in[2] = 1'b1; cyc(4);
    rd(4'd6, 16'h0004);
    gpio_in[2] = 1'b0; cyc(4);
    gpio_in[2] = 1'b1;
    cyc(2);
    wr(4'd6, 16'h0004, 2'b11);
    rd(4'd6, 16'h0004);
    wr(4'd6, 16'h0004, 2'b11);
    rd(4'd6, 16'h0000);

    // Pads high across reset release raise no flags
    gpio_in = 8'hFF;
    rst = 1'b1; cyc(2); rst = 1'b0;
    cyc(100);
    rd(4'd6, 16'h0000);
    rd(4'd5, 16'h00FF);
    rd(4'd0, 16'h0000);

    // Reset asserted in the middle of a write
    wr(4'd4, 16'h00FF, 2'b11);
    wr(4'd0, 16'h003C, 2'b11);
    cyc(1);
    chk("pre_reset_out", 32'(gpio_out), 32'h3C);
    per_en = 1'b1; per_addr = BASE | 8'h0; per_din = 16'h00FF; per_we = 2'b11;
    #2 rst = 1'b1;
    #1;
    chk("midreset_out", 32'(gpio_out), 32'h0);
    chk("midreset_oe", 32'(gpio_oe), 32'h0);
    chk("midreset_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    per_en = 1'b0; per_we = 2'b00;
    rst = 1'b0;
    rd(4'd0, 16'h0000);
    rd(4'd4, 16'h0000);

`ifdef GPIO_BLINK_EN
    wr(4'd4, 16'h0001, 2'b11);
    wr(4'd9, 16'h0001, 2'b11);
    wr(4'd10, 16'h0003, 2'b11);
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      chk($sformatf("blink_k%0d", k), 32'(gpio_out[0]), 32'(((k - 1) / 4) % 2));
    end
    rd(4'd10, 16'h0003);
    wr(4'd10, 16'h0000, 2'b11);
`else
    wr(4'd10, 16'hFFFF, 2'b11);
    wr(4'd9, 16'hFFFF, 2'b11);
    rd(4'd10, 16'h0000);
    rd(4'd9, 16'h0000);
`endif
    cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
